// File: rtl/sdram_read_pkg.sv
// Shared SDRAM read-engine definitions.
// Command encodings, timing defaults and FSM states.
package sdram_read_pkg;

    // {ras_n, cas_n, we_n}
    localparam logic [2:0] SDRAM_CMD_NOP  = 3'b111;
    localparam logic [2:0] SDRAM_CMD_ACT  = 3'b011;
    localparam logic [2:0] SDRAM_CMD_READ = 3'b101;
    localparam logic [2:0] SDRAM_CMD_TERM = 3'b110;
    localparam logic [2:0] SDRAM_CMD_PRE  = 3'b010;

    localparam int CAS_LATENCY_DEF = 2;
    localparam int T_RCD_DEF       = 2;
    localparam int T_RP_DEF        = 2;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_ACTIVE      = 3'd1,
        S_READ_CMD    = 3'd2,
        S_WAIT_DATA   = 3'd3,
        S_READ_BOTTOM = 3'd4,
        S_PRECHARGE   = 3'd5,
        S_WRITE_FIFO  = 3'd6
    } state_t;

endpackage

// File: rtl/sdram_read.sv
// Single-access SDRAM read engine.
// ACT, READ, capture two words, TERM, PRE, push 32 bits to FIFO.
module sdram_read
    import sdram_read_pkg::*;
#(
    parameter int CAS_LATENCY = CAS_LATENCY_DEF,
    parameter int T_RCD       = T_RCD_DEF,
    parameter int T_RP        = T_RP_DEF
) (
    input  logic        clk,
    input  logic        rst,
    output logic [2:0]  command,
    output logic [11:0] address,
    output logic [1:0]  bank,
    output logic [1:0]  data_mask,
    input  logic [15:0] data_in,
    output logic        idle,
    input  logic        enable,
    input  logic        auto_refresh,
    input  logic [21:0] app_address,
    output logic [35:0] fifo_data,
    output logic        fifo_write,
    input  logic        fifo_full
);

    localparam int DW = 4;

    state_t      state_q, state_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [DW-1:0] cas_q, cas_d;
    logic [21:0] read_address_q, read_address_d;
    logic [15:0] top_q, top_d;
    logic [15:0] bottom_q, bottom_d;
    logic [2:0]  command_d;
    logic [11:0] address_d;
    logic [1:0]  bank_d;
    logic [35:0] fifo_data_d;
    logic        fifo_write_d;

    assign data_mask = 2'b00;
    assign idle      = (delay_q == '0) && (state_q == S_IDLE);

    // State, timers, capture registers and registered bus outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            delay_q        <= '0;
            cas_q          <= '0;
            read_address_q <= '0;
            top_q          <= '0;
            bottom_q       <= '0;
            command        <= SDRAM_CMD_NOP;
            address        <= '0;
            bank           <= '0;
            fifo_data      <= '0;
            fifo_write     <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_q        <= delay_d;
            cas_q          <= cas_d;
            read_address_q <= read_address_d;
            top_q          <= top_d;
            bottom_q       <= bottom_d;
            command        <= command_d;
            address        <= address_d;
            bank           <= bank_d;
            fifo_data      <= fifo_data_d;
            fifo_write     <= fifo_write_d;
        end
    end

    // Next-state and next-output decode; a running delay freezes the FSM
    always_comb begin
        state_d        = state_q;
        delay_d        = delay_q;
        cas_d          = cas_q;
        read_address_d = read_address_q;
        top_d          = top_q;
        bottom_d       = bottom_q;
        command_d      = SDRAM_CMD_NOP;
        address_d      = address;
        bank_d         = bank;
        fifo_data_d    = fifo_data;
        fifo_write_d   = 1'b0;

        if (delay_q != '0) begin
            delay_d = delay_q - 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (enable && !fifo_full && !auto_refresh) begin
                        read_address_d = app_address;
                        state_d        = S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    command_d = SDRAM_CMD_ACT;
                    bank_d    = read_address_q[21:20];
                    address_d = read_address_q[19:8];
                    delay_d   = DW'(T_RCD);
                    state_d   = S_READ_CMD;
                end
                S_READ_CMD: begin
                    command_d = SDRAM_CMD_READ;
                    address_d = {4'b0000, read_address_q[7:0]};
                    cas_d     = DW'(CAS_LATENCY);
                    state_d   = S_WAIT_DATA;
                end
                S_WAIT_DATA: begin
                    cas_d = cas_q - 1'b1;
                    if (cas_q <= DW'(1)) begin
                        top_d   = data_in;
                        state_d = S_READ_BOTTOM;
                    end
                end
                S_READ_BOTTOM: begin
                    bottom_d  = data_in;
                    command_d = SDRAM_CMD_TERM;
                    state_d   = S_PRECHARGE;
                end
                S_PRECHARGE: begin
                    command_d      = SDRAM_CMD_PRE;
                    delay_d        = DW'(T_RP);
                    read_address_d = read_address_q + 22'd2;
                    state_d        = S_WRITE_FIFO;
                end
                S_WRITE_FIFO: begin
                    fifo_data_d  = {4'b0000, top_q, bottom_q};
                    fifo_write_d = 1'b1;
                    state_d      = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

endmodule
